fetch_unit: RTL and testbench

Instruction fetch stage: owns the program counter, consumes the next-PC value selected by the jump/branch select logic as a redirect, issues requests to instruction memory over a req/ack handshake, and buffers fetched words in a 2-entry queue presented to decode with valid/ready. It sits between the jump/branch select at the end of execute and instruction decode.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_queue.sv | 29 ++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch state encoding and fetch queue entry type
package cpu_pkg;
  localparam int ADDR_W = 16;
  localparam int INSTR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;
  typedef enum logic [1:0] {BOOT, IDLE, WAIT, KILL} fetch_state_t;
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_if: redirect input, instruction memory req/ack and decode valid/ready bundle
interface fetch_if;
  import cpu_pkg::*;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;
  modport master (
    input  redirect, redirect_pc, imem_ack, imem_rdata, dec_ready,
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc
  );
  modport slave (
    output redirect, redirect_pc, imem_ack, imem_rdata, dec_ready,
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {pc, instr} with push, pop, flush and count
module fetch_queue
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  fq_entry_t din,
  output fq_entry_t head,
  output logic [1:0] count
);
  fq_entry_t  tail;
  logic [1:0] cnt_n;
  assign cnt_n = flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      count <= cnt_n;
      if (!flush) begin
        head <= (pop && count == 2'd2) ? tail : (push && (count == 2'd0 || pop)) ? din : head;
        tail <= (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop))) ? din : tail;
      end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem req/ack sequencer and 2-deep decode queue front end
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] PC_STEP  = 16'd1
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);
  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, addr_n;
  logic              req_n, push, pop, flush, space;
  logic [1:0]        count, cnt_n;
  fq_entry_t         head;
  assign pop   = bus.dec_valid & bus.dec_ready;
  assign flush = bus.redirect & (state != BOOT);
  assign push  = (state == WAIT) & bus.imem_ack & ~bus.redirect;
  assign cnt_n = flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
  assign space = cnt_n < 2'd2;
  fetch_queue u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({pc, bus.imem_rdata}),
    .head  (head),
    .count (count)
  );
  assign bus.dec_valid = |count;
  assign bus.dec_instr = head.instr;
  assign bus.dec_pc    = head.pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_PC;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      bus.imem_req  <= req_n;
      bus.imem_addr <= addr_n;
    end
  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = bus.imem_req;
    addr_n  = bus.imem_addr;
    case (state)
      BOOT: state_n = IDLE;
      IDLE:
        if (bus.redirect || space) begin
          state_n = WAIT;
          req_n   = 1'b1;
          pc_n    = bus.redirect ? bus.redirect_pc : pc;
          addr_n  = pc_n;
        end
      WAIT:
        if (bus.imem_ack && bus.redirect) begin
          pc_n   = bus.redirect_pc;
          addr_n = bus.redirect_pc;
        end else if (bus.imem_ack) begin
          pc_n    = pc + PC_STEP;
          addr_n  = pc_n;
          state_n = space ? WAIT : IDLE;
          req_n   = space;
        end else if (bus.redirect) begin
          // the in-flight address must stay stable until its ack is swallowed in KILL
          pc_n    = bus.redirect_pc;
          state_n = KILL;
        end
      KILL:
        if (bus.imem_ack) begin
          pc_n    = bus.redirect ? bus.redirect_pc : pc;
          addr_n  = pc_n;
          state_n = WAIT;
        end else if (bus.redirect) begin
          pc_n = bus.redirect_pc;
        end
      default: state_n = BOOT;
    endcase
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of expected decode-side {pc, instr}
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_on = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];
  fetch_if bus();
  fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    bus.redirect   = 1'b0;
    bus.imem_ack   = mem_on & bus.imem_req;
    bus.imem_rdata = mem_on ? 16'h1000 + bus.imem_addr : 16'h0000;
  endtask
  initial begin
    logic [31:0] e;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0000;
    bus.dec_ready   = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (rst_n && bus.dec_valid && bus.dec_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got pc=%h instr=%h, required no output", bus.dec_pc, bus.dec_instr);
          end else begin
            e = exp_q.pop_front();
            if ({bus.dec_pc, bus.dec_instr} !== e) begin
              errors++;
              $display("FAIL pop_data: got pc=%h instr=%h, required pc=%h instr=%h",
                       bus.dec_pc, bus.dec_instr, e[31:16], e[15:0]);
            end
          end
        end
      end
    join_none
    repeat (3) tick();
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", {16'd0, bus.imem_addr}, 32'h0000);
    chk("rst_valid", {31'd0, bus.dec_valid}, 32'd0);
    chk("rst_dec_pc", {16'd0, bus.dec_pc}, 32'd0);
    chk("rst_dec_instr", {16'd0, bus.dec_instr}, 32'd0);
    for (int i = 0; i < 5; i++) exp_q.push_back({16'(i), 16'h1000 + 16'(i)});
    mem_on = 1'b1;
    bus.dec_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("boot_req_low", {31'd0, bus.imem_req}, 32'd0);
    tick();
    chk("start_req", {31'd0, bus.imem_req}, 32'd1);
    chk("start_addr", {16'd0, bus.imem_addr}, 32'h0000);
    tick();
    chk("stream_addr1", {16'd0, bus.imem_addr}, 32'h0001);
    tick();
    chk("stream_addr2", {16'd0, bus.imem_addr}, 32'h0002);
    tick();
    chk("stream_addr3", {16'd0, bus.imem_addr}, 32'h0003);
    bus.dec_ready = 1'b0;
    tick();
    chk("bp_req_drop", {31'd0, bus.imem_req}, 32'd0);
    tick();
    tick();
    chk("bp_req_held", {31'd0, bus.imem_req}, 32'd0);
    chk("bp_full_valid", {31'd0, bus.dec_valid}, 32'd1);
    chk("bp_head_pc", {16'd0, bus.dec_pc}, 32'h0002);
    bus.dec_ready = 1'b1;
    tick();
    chk("bp_resume_req", {31'd0, bus.imem_req}, 32'd1);
    chk("bp_resume_addr", {16'd0, bus.imem_addr}, 32'h0004);
    mem_on = 1'b0;
    tick();
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    tick();
    chk("kill_req_held", {31'd0, bus.imem_req}, 32'd1);
    chk("kill_addr_held", {16'd0, bus.imem_addr}, 32'h0005);
    tick();
    tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'hDEAD;
    tick();
    chk("kill_next_req", {31'd0, bus.imem_req}, 32'd1);
    chk("kill_next_addr", {16'd0, bus.imem_addr}, 32'h0040);
    chk("kill_no_valid", {31'd0, bus.dec_valid}, 32'd0);
    bus.dec_ready = 1'b0;
    mem_on = 1'b1;
    tick();
    tick();
    chk("pre_flush_valid", {31'd0, bus.dec_valid}, 32'd1);
    chk("pre_flush_addr", {16'd0, bus.imem_addr}, 32'h0041);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    exp_q.push_back({16'hFFFF, 16'h0FFF});
    exp_q.push_back({16'h0000, 16'h1000});
    tick();
    chk("flush_valid", {31'd0, bus.dec_valid}, 32'd0);
    chk("flush_addr", {16'd0, bus.imem_addr}, 32'hFFFF);
    chk("flush_req", {31'd0, bus.imem_req}, 32'd1);
    bus.dec_ready = 1'b1;
    tick();
    chk("wrap_addr", {16'd0, bus.imem_addr}, 32'h0000);
    tick();
    mem_on = 1'b0;
    tick();
    chk("tail_valid", {31'd0, bus.dec_valid}, 32'd1);
    chk("tail_pc", {16'd0, bus.dec_pc}, 32'h0001);
    chk("tail_instr", {16'd0, bus.dec_instr}, 32'h1001);
    bus.dec_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("async_rst_valid", {31'd0, bus.dec_valid}, 32'd0);
    chk("async_rst_addr", {16'd0, bus.imem_addr}, 32'h0000);
    chk("async_rst_dec_pc", {16'd0, bus.dec_pc}, 32'h0000);
    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
